// File: rtl/match_pkg.sv
// Shared definitions for the A/B equality-run stimulus generator:
// one-hot FSM states, default detector threshold and LFSR tap mask.
package match_pkg;

  typedef enum logic [3:0] {
    GS_IDLE  = 4'b0001,
    GS_RUN   = 4'b0010,
    GS_BREAK = 4'b0100,
    GS_DONE  = 4'b1000
  } gstate_e;

  localparam int THRESH_DEF = 4;

  // Fibonacci taps 8,6,5,4 mapped onto bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR; shifts left when enabled, output is the MSB.
module lfsr8 import match_pkg::*; #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_o
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= SEED;
    else if (en_i) lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign bit_o = lfsr_q[7];

endmodule

// File: rtl/match_seq_gen.sv
// A/B equality-run stimulus transmitter. Data source selected by
// MATCH_GEN_LFSR_EN (LFSR) or, when undefined, an alternating 0,1,... bit.
module match_seq_gen import match_pkg::*; #(
  parameter int         LEN_W  = 6,
  parameter int         THRESH = THRESH_DEF,
  parameter logic [7:0] SEED   = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic             tail_mismatch,
  output logic             A,
  output logic             B,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] exp_hits
);

  localparam logic [LEN_W-1:0] TH = LEN_W'(THRESH);

  gstate_e          state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] hits_q, hits_d;
  logic             tail_q, tail_d;
  logic             a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic             start_acc, emit_run, emit_brk, d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tail_d    = tail_q;
    hits_d    = hits_q;
    start_acc = 1'b0;
    case (state_q)
      GS_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          cnt_d     = run_len;
          tail_d    = tail_mismatch;
          hits_d    = (run_len >= TH) ? (run_len - TH + LEN_W'(1)) : '0;
          if (run_len != '0)     state_d = GS_RUN;
          else if (tail_mismatch) state_d = GS_BREAK;
          else                    state_d = GS_DONE;
        end
      end
      GS_RUN: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = tail_q ? GS_BREAK : GS_DONE;
      end
      GS_BREAK: state_d = GS_DONE;
      GS_DONE:  state_d = GS_IDLE;
      default:  state_d = GS_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign emit_run = (state_d == GS_RUN);
  assign emit_brk = (state_d == GS_BREAK);

`ifdef MATCH_GEN_LFSR_EN
  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (emit_run | emit_brk),
    .bit_o (d)
  );
`else
  logic tgl_q, tgl_d;
  logic unused_seed;
  assign unused_seed = ^SEED;

  // Each accepted start restarts the pattern at 0; only RUN cycles toggle it.
  assign d     = start_acc ? 1'b0 : tgl_q;
  assign tgl_d = emit_run ? ~d : d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tgl_q <= 1'b0;
    else        tgl_q <= tgl_d;
  end
`endif

  always_comb begin
    valid_d = emit_run | emit_brk;
    a_d     = valid_d & d;
    b_d     = emit_run ? d : (emit_brk ? ~d : 1'b0);
    busy_d  = (state_d != GS_IDLE);
    done_d  = (state_d == GS_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GS_IDLE;
      cnt_q   <= '0;
      tail_q  <= 1'b0;
      hits_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      hits_q  <= hits_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign exp_hits = hits_q;

endmodule

// File: tb/tb_match_seq_gen.sv
// Scoreboard bench for match_seq_gen: stimulus pushes expected pairs and
// done events; a negedge monitor pops and compares them.
module tb_match_seq_gen;

  localparam int LEN_W = 6;

`ifdef MATCH_GEN_LFSR_EN
  localparam bit CHK_DATA = 1'b0;
`else
  localparam bit CHK_DATA = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] run_len = '0;
  logic             tail_mismatch = 1'b0;
  logic             A, B, valid, busy, done;
  logic [LEN_W-1:0] exp_hits;

  int checks = 0;
  int errors = 0;

  typedef enum int {K_EQ, K_BRK, K_DONE} kind_e;
  typedef struct {
    kind_e kind;
    bit    a;
    bit    b;
    int    hits;
  } exp_t;

  exp_t q[$];

  match_seq_gen #(.LEN_W(LEN_W), .THRESH(4), .SEED(8'hA5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .run_len       (run_len),
    .tail_mismatch (tail_mismatch),
    .A             (A),
    .B             (B),
    .valid         (valid),
    .busy          (busy),
    .done          (done),
    .exp_hits      (exp_hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int len, input bit tail, input int hits);
    exp_t e;
    bit   dd = 1'b0;
    for (int i = 0; i < len; i++) begin
      e.kind = K_EQ; e.a = dd; e.b = dd; e.hits = 0;
      q.push_back(e);
      dd = ~dd;
    end
    if (tail) begin
      e.kind = K_BRK; e.a = dd; e.b = ~dd; e.hits = 0;
      q.push_back(e);
    end
    e.kind = K_DONE; e.a = 1'b0; e.b = 1'b0; e.hits = hits;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (valid) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("pair_kind", (A == B) ? int'(K_EQ) : int'(K_BRK), int'(e.kind));
          if (CHK_DATA) begin
            chk("pair_A", int'(A), int'(e.a));
            chk("pair_B", int'(B), int'(e.b));
          end
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_kind", int'(K_DONE), int'(e.kind));
          chk("done_exp_hits", int'(exp_hits), e.hits);
          chk("done_AB", int'({A, B, valid}), 0);
        end
      end
    end
  end

  // poke >= 0 re-pulses start (run_len=9) at that busy-cycle index.
  task automatic run_txn(input int len, input bit tail, input int hits,
                         input int exp_busy, input int poke);
    int bc  = 0;
    bit fin = 1'b0;
    @(negedge clk);
    start = 1'b1; run_len = LEN_W'(len); tail_mismatch = tail;
    push_exp(len, tail, hits);
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) begin
        bc++;
        if (i == poke) begin
          start = 1'b1; run_len = LEN_W'(9); tail_mismatch = 1'b0;
        end
      end else fin = 1'b1;
    end
    chk("txn_finished", int'(fin), 1);
    chk("busy_cycles", bc, exp_busy);
    chk("exp_hits_hold", int'(exp_hits), hits);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_A", int'(A), 0);
    chk("rst_B", int'(B), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_exp_hits", int'(exp_hits), 0);

    run_txn(5, 1'b1, 2, 7, -1);
    run_txn(3, 1'b0, 0, 4, -1);
    run_txn(0, 1'b1, 0, 2, -1);
    run_txn(0, 1'b0, 0, 1, -1);
    run_txn(6, 1'b1, 3, 8, 2);     // start during RUN ignored
    run_txn(4, 1'b0, 1, 5, 4);     // start during DONE ignored
    run_txn(63, 1'b0, 60, 64, -1); // all-ones run length
    chk("idle_after_ignored", int'(busy), 0);

    @(negedge clk);
    start = 1'b1; run_len = LEN_W'(20); tail_mismatch = 1'b1;
    push_exp(20, 1'b1, 17);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_AB", int'({A, B}), 0);
    chk("abort_exp_hits", int'(exp_hits), 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_txn(3, 1'b1, 0, 5, -1);

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_seq_gen.md
Name: match_seq_gen

Overview:
- Stimulus transmitter for the A/B equality-run protocol: drives A/B pairs whose runs of A==B are terminated by a forced mismatch.
- Downstream equality-run detectors consume these pairs; the block is the sending end of that link.
- Used in lab builds and benches to exercise detectors with programmable run lengths.
- Also reports how many detector output-high cycles the generated run must produce.

Parameters:
- LEN_W, 6, width of run_len and the internal run counter.
- THRESH, 4, consecutive-equal count at which the detector output first asserts; used for the exp_hits computation.
- SEED, 8'hA5, LFSR reset seed; must be nonzero.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. 0 resets, 1 runs.
- start  in  1  request pulse; sampled only in IDLE.
- run_len  in  LEN_W  number of equal cycles to emit; captured with start.
- tail_mismatch  in  1  1 = emit one A!=B cycle after the run; captured with start.
- A  out  1  stimulus bit A, registered.
- B  out  1  stimulus bit B, registered.
- valid  out  1  A/B meaningful this cycle.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse in DONE.
- exp_hits  out  LEN_W  expected detector Out-high cycles for the captured request.

Behaviour:
- Reset (reset=0, async): state=IDLE; A=0, B=0, valid=0, busy=0, done=0, exp_hits=0; counter=0; LFSR=SEED. Deassertion takes effect on the next clk edge.
- FSM is one-hot, 4 states: IDLE, RUN, BREAK, DONE. Any illegal encoding goes to IDLE next cycle.
- All outputs are registered.

IDLE:
- valid=0, busy=0.
- When start=1 (edge N), capture run_len into cnt and capture tail_mismatch.
- Set exp_hits = (run_len >= THRESH) ? run_len-THRESH+1 : 0, computed at LEN_W width with no underflow.
- Next state is RUN if run_len != 0. Otherwise next state is BREAK if tail_mismatch=1, else DONE.

RUN:
- Each cycle: valid=1, A=B=d, where d is the LFSR bit. The LFSR advances every RUN cycle.
- cnt decrements each cycle. The first valid pair appears on the cycle after edge N.
- On the last run cycle (cnt==1), go to BREAK if the captured tail_mismatch=1, else DONE.
- Exactly run_len cycles of valid=1 with A==B.

BREAK:
- One cycle: valid=1, A=d, B=~d. Then go to DONE.

DONE:
- One cycle: done=1, valid=0, A=B=0. Then go to IDLE.
- busy is low on the following cycle.
- exp_hits holds its value until the next accepted start.

LFSR:
- 8-bit Fibonacci, taps 8,6,5,4; shifts only in RUN and BREAK.

Boundary conditions:
- start while busy is ignored; no queuing.
- start in the same cycle as the DONE pulse is ignored.
- run_len = all-ones gives 2^LEN_W-1 equal cycles.
- reset low mid-run aborts immediately to the reset values.

Optional Feature:
- Macro: MATCH_GEN_LFSR_EN.
- Defined: d comes from the LFSR as described above.
- Undefined: no LFSR is instantiated and d alternates 0,1,0,1… starting at 0 on each run, so A toggles while A==B still holds.
- The SEED parameter is ignored when the macro is undefined.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package match_pkg holds:
  - one-hot state constants GS_IDLE=4'b0001, GS_RUN=4'b0010, GS_BREAK=4'b0100, GS_DONE=4'b1000;
  - the default THRESH;
  - the LFSR tap mask.
- Sub-module lfsr8 (enable, seed, bit out) is natural. It is instantiated only under MATCH_GEN_LFSR_EN.

Test Plan:
1. Reset held low 3 cycles, release -> all outputs 0, busy=0.
2. start with run_len=5, tail_mismatch=1 -> 5 cycles valid with A==B, 1 cycle A!=B, done pulse; exp_hits=2; busy high for 7 cycles.
3. run_len=3, tail_mismatch=0 -> 3 equal cycles, no BREAK, exp_hits=0.
4. run_len=0, tail_mismatch=1 -> single BREAK cycle then done; run_len=0, tail_mismatch=0 -> done on the cycle after start.
5. start re-pulsed during RUN with run_len=9 -> ignored; exp_hits unchanged; run completes with the original length.
6. reset driven low in the 2nd RUN cycle of run_len=20 -> valid, busy and A/B drop asynchronously. A fresh start after release begins a new run; with LFSR_EN, the LFSR restarts from SEED.
